// File: rtl/light_countdown_display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : light_countdown_display_pkg                                    |
// | Brief    : Shared types and constants for the traffic-light countdown     |
// |            display: state encodings, segment type, BCD helper.            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package light_countdown_display_pkg;

  // Controller state as seen on the 3-bit state input.
  typedef logic [2:0] state_t;

  localparam state_t S0 = 3'd0;
  localparam state_t S1 = 3'd1;
  localparam state_t S2 = 3'd2;
  localparam state_t S3 = 3'd3;
  localparam state_t S4 = 3'd4;

  // Seven-segment drive, index 0..6 = segments a..g, active-low.
  typedef logic [0:6] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b1111110;

  // Two-digit BCD value.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  // Convert a 0..99 integer into two BCD digits (used for parameter loads).
  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = 4'((v / 10) % 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/light_countdown_display_seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_decode                                                    |
// | Brief    : Combinational BCD digit to active-low seven-segment decoder.   |
// |            Non-decimal codes (10..15) decode to a blank digit.            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seg7_decode
  import light_countdown_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);

  // Digit lookup; anything outside 0..9 is shown dark rather than garbage.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'b0000001;
      4'd1:    o_seg = 7'b1001111;
      4'd2:    o_seg = 7'b0010010;
      4'd3:    o_seg = 7'b0000110;
      4'd4:    o_seg = 7'b1001100;
      4'd5:    o_seg = 7'b0100100;
      4'd6:    o_seg = 7'b0100000;
      4'd7:    o_seg = 7'b0001111;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0000100;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/light_countdown_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : light_countdown_display                                        |
// | Brief    : Per-state BCD seconds countdown for a traffic-light controller |
// |            with registered seven-segment outputs and an expiry pulse.     |
// |            Optional macro COUNTDOWN_BLINK_EN blinks the last seconds.     |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module light_countdown_display
  import light_countdown_display_pkg::*;
#(
  parameter int S1_SECS      = 10,
  parameter int S2_SECS      = 20,
  parameter int S4_SECS      = 10,
  parameter int BLINK_THRESH = 3
) (
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic       tick_1hz,
  input  logic [2:0] state,
  output logic       done,
  output seg_t       HEX3,
  output seg_t       HEX2,
  output seg_t       HEX1,
  output seg_t       HEX0
);

  // Parameter sanity: trap out-of-range configurations at elaboration.
  if ((S1_SECS < 1) || (S1_SECS > 99)) begin : g_s1_range
    $error("S1_SECS must be in 1..99");
  end
  if ((S2_SECS < 1) || (S2_SECS > 99)) begin : g_s2_range
    $error("S2_SECS must be in 1..99");
  end
  if ((S4_SECS < 1) || (S4_SECS > 99)) begin : g_s4_range
    $error("S4_SECS must be in 1..99");
  end
  if ((BLINK_THRESH < 0) || (BLINK_THRESH > 99)) begin : g_thresh_range
    $error("BLINK_THRESH must be in 0..99");
  end

  localparam bcd2_t c_s1_load = to_bcd2(S1_SECS);
  localparam bcd2_t c_s2_load = to_bcd2(S2_SECS);
  localparam bcd2_t c_s4_load = to_bcd2(S4_SECS);

  state_t     r_state_q;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic       r_zero_pend;  // decrement 01->00 happened last edge
  logic       r_done;

  logic       w_state_chg;
  logic       w_nonzero;
  logic       w_last;
  logic       w_dec;
  logic       w_valid;
  logic       w_show_count;
  logic       w_blink_off;
  bcd2_t      w_load;
  bcd2_t      w_next_dec;
  logic [3:0] w_state_bcd;
  seg_t       w_seg2;
  seg_t       w_seg1;
  seg_t       w_seg0;

  assign w_state_chg  = (state != r_state_q);
  assign w_nonzero    = (r_tens != 4'd0) || (r_ones != 4'd0);
  assign w_last       = (r_tens == 4'd0) && (r_ones == 4'd1);
  // A state change swallows a coincident tick; ticks at 00 are ignored.
  assign w_dec        = !w_state_chg && tick_1hz && w_nonzero;
  assign w_valid      = (r_state_q <= S4);
  assign w_show_count = (r_state_q == S1) || (r_state_q == S2) || (r_state_q == S4);
  assign w_state_bcd  = {1'b0, r_state_q};

  // Load value for the state being entered; idle and invalid states load 00.
  always_comb begin
    w_load = '0;
    case (state)
      S1:      w_load = c_s1_load;
      S2:      w_load = c_s2_load;
      S4:      w_load = c_s4_load;
      default: w_load = '0;
    endcase
  end

  // BCD decrement with borrow from the tens digit.
  always_comb begin
    w_next_dec = {r_tens, r_ones};
    if (r_ones == 4'd0) begin
      w_next_dec.tens = r_tens - 4'd1;
      w_next_dec.ones = 4'd9;
    end else begin
      w_next_dec.ones = r_ones - 4'd1;
    end
  end

  // Count, tracked state and expiry pulse pipeline.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      r_state_q   <= S0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_zero_pend <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= r_zero_pend;
      r_zero_pend <= w_dec && w_last;
      if (w_state_chg) begin
        r_state_q <= state;
        r_tens    <= w_load.tens;
        r_ones    <= w_load.ones;
      end else if (w_dec) begin
        r_tens <= w_next_dec.tens;
        r_ones <= w_next_dec.ones;
      end
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  logic       r_blink_off;
  logic [6:0] w_next_val;
  logic       w_in_blink;

  assign w_next_val  = (7'(w_next_dec.tens) * 7'd10) + 7'(w_next_dec.ones);
  assign w_in_blink  = (w_next_val != 7'd0) && (w_next_val <= 7'(BLINK_THRESH));
  assign w_blink_off = r_blink_off;

  // Toggle visibility on each second inside the blink window; clear otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      r_blink_off <= 1'b0;
    end else if (w_state_chg) begin
      r_blink_off <= 1'b0;
    end else if (w_dec) begin
      if (w_last) begin
        r_blink_off <= 1'b0;
      end else if (w_in_blink) begin
        r_blink_off <= !r_blink_off;
      end
    end
  end
`else
  assign w_blink_off = 1'b0;
`endif

  seg7_decode u_dec_state (
    .i_bcd (w_state_bcd),
    .o_seg (w_seg2)
  );

  seg7_decode u_dec_tens (
    .i_bcd (r_tens),
    .o_seg (w_seg1)
  );

  seg7_decode u_dec_ones (
    .i_bcd (r_ones),
    .o_seg (w_seg0)
  );

  // Registered display: one cycle behind the count/state registers.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      HEX3 <= SEG_BLANK;
      HEX2 <= SEG_BLANK;
      HEX1 <= SEG_BLANK;
      HEX0 <= SEG_BLANK;
    end else if (!w_valid) begin
      HEX3 <= SEG_DASH;
      HEX2 <= SEG_DASH;
      HEX1 <= SEG_DASH;
      HEX0 <= SEG_DASH;
    end else begin
      HEX3 <= SEG_BLANK;
      HEX2 <= w_seg2;
      if (!w_show_count) begin
        HEX1 <= SEG_DASH;
        HEX0 <= SEG_DASH;
      end else if (w_blink_off) begin
        HEX1 <= SEG_BLANK;
        HEX0 <= SEG_BLANK;
      end else begin
        HEX1 <= w_seg1;
        HEX0 <= w_seg0;
      end
    end
  end

  assign done = r_done;

endmodule
`default_nettype wire
